// File: rtl/h2c_keep_to_mty_adapter_pkg.sv
// Shared widths, H2C sideband types and keep helpers for the keep-to-mty adapter.
package h2c_adapter_pkg;
  localparam int DATA_W  = 512;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int MTY_W   = $clog2(KEEP_W);
  localparam int QID_W   = 11;
  localparam int PORT_W  = 3;
  localparam int MDATA_W = 32;
  localparam int LEN_W   = 16;

  typedef enum logic {ST_IDLE, ST_IN_PKT} h2c_state_e;

  typedef struct packed {
    logic [MTY_W-1:0]   mty;
    logic               zero_byte;
    logic               err;
    logic [MDATA_W-1:0] mdata;
    logic [QID_W-1:0]   qid;
    logic [PORT_W-1:0]  port_id;
  } h2c_tuser_t;

  // Running length rides with the beat so stats can update at output handshake.
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    h2c_tuser_t        tuser;
    logic [LEN_W-1:0]  len;
  } h2c_beat_t;

  function automatic logic [MTY_W-1:0] keep_msb_idx(input logic [KEEP_W-1:0] keep);
    logic [MTY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEEP_W; i++)
      if (keep[i]) idx = MTY_W'(i);
    return idx;
  endfunction

  // 2^n-1 patterns (including 0 and all-ones) have no bits shared with keep+1.
  function automatic logic keep_is_contig(input logic [KEEP_W-1:0] keep);
    logic [KEEP_W-1:0] inc;
    inc = keep + KEEP_W'(1);
    return (keep & inc) == '0;
  endfunction
endpackage

// File: rtl/h2c_keep_to_mty_adapter_if.sv
// Stream interfaces: tkeep-based AXI4-Stream in, QDMA H2C sideband format out.
interface axis_keep_if;
  import h2c_adapter_pkg::*;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

interface h2c_axis_if;
  import h2c_adapter_pkg::*;
  logic [DATA_W-1:0]  tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [MTY_W-1:0]   tuser_mty;
  logic               tuser_zero_byte;
  logic               tuser_err;
  logic [MDATA_W-1:0] tuser_mdata;
  logic [QID_W-1:0]   tuser_qid;
  logic [PORT_W-1:0]  tuser_port_id;
  logic [31:0]        tcrc;

  modport master (output tdata, tvalid, tlast, tuser_mty, tuser_zero_byte, tuser_err,
                         tuser_mdata, tuser_qid, tuser_port_id, tcrc,
                  input  tready);
  modport slave  (input  tdata, tvalid, tlast, tuser_mty, tuser_zero_byte, tuser_err,
                         tuser_mdata, tuser_qid, tuser_port_id, tcrc,
                  output tready);
endinterface

// File: rtl/h2c_keep_to_mty_adapter_skid.sv
// Two-entry register slice: output register plus one skid entry, registered ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         in_fire;
  logic         out_open;

  assign in_fire  = in_valid & in_ready;
  assign out_open = ~out_valid | out_ready;

  // in_ready tracks "skid empty", so a beat can only land in skid while it is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else if (out_open) begin
      in_ready <= 1'b1;
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end
endmodule

// File: rtl/h2c_keep_to_mty_adapter.sv
// tkeep AXI4-Stream to QDMA H2C tuser format: keep checks, length, SOP sideband, stats.
module h2c_keep_to_mty_adapter
  import h2c_adapter_pkg::*;
(
  input  logic               axis_aclk,
  input  logic               aresetn,
  axis_keep_if.slave         s_axis,
  h2c_axis_if.master         m_axis,
  input  logic [QID_W-1:0]   cfg_qid,
  input  logic [PORT_W-1:0]  cfg_port_id,
  input  logic [MDATA_W-1:0] cfg_mdata,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               pkt_len_valid,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        err_cnt
);
  h2c_state_e         state_q, state_d;
  logic [QID_W-1:0]   qid_q;
  logic [PORT_W-1:0]  port_q;
  logic [MDATA_W-1:0] mdata_q;
  logic               err_q;
  logic [LEN_W-1:0]   len_q;

  logic               in_fire, sop, zero, bad, beat_err, out_fire;
  logic [MTY_W-1:0]   msb, mty;
  logic [LEN_W-1:0]   len_base, len_add, len_next;
  logic [LEN_W:0]     len_sum;
  h2c_beat_t          in_beat, out_beat;

  always_comb begin
    in_fire  = s_axis.tvalid & s_axis.tready;
    sop      = (state_q == ST_IDLE);
    zero     = (s_axis.tkeep == '0);
    msb      = keep_msb_idx(s_axis.tkeep);
    // zero_byte is only legal as a whole single-beat packet
    if (s_axis.tlast) bad = ~keep_is_contig(s_axis.tkeep) | (zero & ~sop);
    else              bad = (s_axis.tkeep != '1);
    beat_err = bad | (err_q & ~sop);
    mty      = (s_axis.tlast & ~zero) ? MTY_W'(KEEP_W - 1) - msb : '0;
    if (!s_axis.tlast) len_add = LEN_W'(KEEP_W);
    else if (zero)     len_add = '0;
    else               len_add = LEN_W'(msb) + LEN_W'(1);
    len_base = sop ? '0 : len_q;
    len_sum  = {1'b0, len_base} + {1'b0, len_add};
    len_next = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    in_beat.tdata           = s_axis.tdata;
    in_beat.tlast           = s_axis.tlast;
    in_beat.tuser.mty       = mty;
    in_beat.tuser.zero_byte = s_axis.tlast & zero;
    in_beat.tuser.err       = beat_err;
    in_beat.tuser.mdata     = sop ? cfg_mdata   : mdata_q;
    in_beat.tuser.qid       = sop ? cfg_qid     : qid_q;
    in_beat.tuser.port_id   = sop ? cfg_port_id : port_q;
    in_beat.len             = len_next;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_fire && !s_axis.tlast) state_d = ST_IN_PKT;
      ST_IN_PKT: if (in_fire &&  s_axis.tlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge axis_aclk) begin
    if (!aresetn) begin
      qid_q   <= '0;
      port_q  <= '0;
      mdata_q <= '0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else if (in_fire) begin
      if (sop) begin
        qid_q   <= cfg_qid;
        port_q  <= cfg_port_id;
        mdata_q <= cfg_mdata;
      end
      err_q <= beat_err;
      len_q <= len_next;
    end
  end

  axis_skid_buffer #(.W($bits(h2c_beat_t))) u_skid (
    .clk       (axis_aclk),
    .rst_n     (aresetn),
    .in_data   (in_beat),
    .in_valid  (s_axis.tvalid),
    .in_ready  (s_axis.tready),
    .out_data  (out_beat),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tdata           = out_beat.tdata;
  assign m_axis.tlast           = out_beat.tlast;
  assign m_axis.tuser_mty       = out_beat.tuser.mty;
  assign m_axis.tuser_zero_byte = out_beat.tuser.zero_byte;
  assign m_axis.tuser_err       = out_beat.tuser.err;
  assign m_axis.tuser_mdata     = out_beat.tuser.mdata;
  assign m_axis.tuser_qid       = out_beat.tuser.qid;
  assign m_axis.tuser_port_id   = out_beat.tuser.port_id;
  assign m_axis.tcrc            = '0;
  assign out_fire               = m_axis.tvalid & m_axis.tready;

  always_ff @(posedge axis_aclk) begin
    if (!aresetn) begin
      pkt_len       <= '0;
      pkt_len_valid <= 1'b0;
      pkt_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      pkt_len_valid <= out_fire & out_beat.tlast;
      if (out_fire && out_beat.tlast) begin
        pkt_len <= out_beat.len;
        pkt_cnt <= pkt_cnt + 32'd1;
        if (out_beat.tuser.err) err_cnt <= err_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_h2c_keep_to_mty_adapter.sv
// Random + directed bench for h2c_keep_to_mty_adapter against a packet-level model.
module tb_h2c_keep_to_mty_adapter;
  import h2c_adapter_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic [QID_W-1:0]   cfg_qid = '0;
  logic [PORT_W-1:0]  cfg_port_id = '0;
  logic [MDATA_W-1:0] cfg_mdata = '0;
  logic [LEN_W-1:0]   pkt_len;
  logic               pkt_len_valid;
  logic [31:0]        pkt_cnt, err_cnt;

  axis_keep_if s_axis();
  h2c_axis_if  m_axis();

  h2c_keep_to_mty_adapter dut (
    .axis_aclk     (clk),
    .aresetn       (aresetn),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .cfg_qid       (cfg_qid),
    .cfg_port_id   (cfg_port_id),
    .cfg_mdata     (cfg_mdata),
    .pkt_len       (pkt_len),
    .pkt_len_valid (pkt_len_valid),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                mty;
    logic              zb;
    logic              err;
    logic [31:0]       mdata;
    logic [10:0]       qid;
    logic [2:0]        port;
    int                len;
  } beat_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // packet-level reference state
  beat_t       exp_q[$], obs_q[$];
  bit          mi_in_pkt = 0, mi_err = 0;
  int          mi_len = 0;
  logic [10:0] mi_qid;
  logic [2:0]  mi_port;
  logic [31:0] mi_mdata;
  logic [31:0] exp_cnt = 0, exp_errc = 0;
  bit          st_pend = 0;
  int          st_len = 0, last_plen = -1;
  bit          stall_prev = 0;
  logic [575:0] snap_prev;
  int          m_mode = 1;
  bit          cfg_rand = 0;

  function automatic logic [575:0] out_snap();
    return 576'({m_axis.tvalid, m_axis.tdata, m_axis.tlast, m_axis.tuser_mty,
                 m_axis.tuser_zero_byte, m_axis.tuser_err, m_axis.tuser_mdata,
                 m_axis.tuser_qid, m_axis.tuser_port_id});
  endfunction

  task automatic model_in();
    beat_t b;
    logic [63:0] k;
    int ones, hi;
    bit sop, bad;
    k = s_axis.tkeep;
    ones = 0; hi = -1;
    for (int i = 0; i < 64; i++) if (k[i]) begin ones++; hi = i; end
    sop = !mi_in_pkt;
    if (sop) begin
      mi_qid = cfg_qid; mi_port = cfg_port_id; mi_mdata = cfg_mdata;
      mi_err = 0; mi_len = 0;
    end
    b.data = s_axis.tdata;
    b.last = s_axis.tlast;
    if (s_axis.tlast) begin
      b.zb   = (ones == 0);
      b.mty  = b.zb ? 0 : 63 - hi;
      bad    = (ones != hi + 1) || (b.zb && !sop);
      mi_len = mi_len + hi + 1;
    end else begin
      b.zb = 0; b.mty = 0;
      bad  = (ones != 64);
      mi_len = mi_len + 64;
    end
    if (mi_len > 65535) mi_len = 65535;
    mi_err = mi_err | bad;
    b.err = mi_err; b.mdata = mi_mdata; b.qid = mi_qid; b.port = mi_port; b.len = mi_len;
    mi_in_pkt = !s_axis.tlast;
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (!aresetn) begin
      exp_q.delete();
      mi_in_pkt = 0; exp_cnt = 0; exp_errc = 0; st_pend = 0; stall_prev = 0;
    end else begin
      if (st_pend) begin
        chk("plv", pkt_len_valid, 1);
        chk("pkt_len", pkt_len, st_len);
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        chk("err_cnt", err_cnt, exp_errc);
        last_plen = int'(pkt_len);
        st_pend = 0;
      end else if (pkt_len_valid) chk("plv_spurious", pkt_len_valid, 0);
      if (stall_prev) chk("hold", out_snap(), snap_prev);
      stall_prev = m_axis.tvalid && !m_axis.tready;
      snap_prev  = out_snap();
      if (s_axis.tvalid && s_axis.tready) model_in();
      if (m_axis.tvalid && m_axis.tready) begin
        beat_t o, e;
        o.data = m_axis.tdata; o.last = m_axis.tlast; o.mty = int'(m_axis.tuser_mty);
        o.zb = m_axis.tuser_zero_byte; o.err = m_axis.tuser_err; o.mdata = m_axis.tuser_mdata;
        o.qid = m_axis.tuser_qid; o.port = m_axis.tuser_port_id; o.len = 0;
        obs_q.push_back(o);
        chk("crc", m_axis.tcrc, 0);
        if (exp_q.size() == 0) chk("exp_beat_pending", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("o_data", o.data, e.data);
          chk("o_last", o.last, e.last);
          chk("o_mty", o.mty, e.mty);
          chk("o_zb", o.zb, e.zb);
          chk("o_err", o.err, e.err);
          chk("o_mdata", o.mdata, e.mdata);
          chk("o_qid", o.qid, e.qid);
          chk("o_port", o.port, e.port);
          if (e.last) begin
            exp_cnt++;
            if (e.err) exp_errc++;
            st_pend = 1; st_len = e.len;
          end
        end
      end
    end
  end

  // sink ready and cfg change at posedge+2 so tests can retarget at posedge+1
  always @(posedge clk) begin
    #2;
    case (m_mode)
      0:       m_axis.tready = 1'b0;
      1:       m_axis.tready = 1'b1;
      default: m_axis.tready = ($urandom_range(3) != 0);
    endcase
    if (cfg_rand) begin
      cfg_qid = 11'($urandom); cfg_port_id = 3'($urandom); cfg_mdata = $urandom;
    end
  end

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] ones_keep(input int n);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  // call at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [63:0] k, input logic l);
    int n;
    s_axis.tdata = d; s_axis.tkeep = k; s_axis.tlast = l; s_axis.tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis.tready && n < 500) begin n++; @(negedge clk); end
    if (n >= 500) chk("send_timeout", s_axis.tready, 1);
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input logic [63:0] mid_k, input logic [63:0] last_k);
    for (int i = 0; i < nb; i++)
      send_beat(rnd_data(), (i == nb - 1) ? last_k : mid_k, i == nb - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_pend || m_axis.tvalid) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t o;
    longint t0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
    m_axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", m_axis.tvalid, 0);
    chk("rst_sready", s_axis.tready, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_pkt_len", {pkt_len_valid, pkt_len}, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_sready", s_axis.tready, 1);
    @(posedge clk); #1;

    // two-beat, cfg changes mid-packet
    obs_q.delete();
    cfg_qid = 11'h12; cfg_port_id = 3'd5; cfg_mdata = 32'h4A;
    send_beat(rnd_data(), '1, 1'b0);
    cfg_qid = 11'h7ff; cfg_port_id = 3'd1; cfg_mdata = 32'hDEAD;
    send_beat(rnd_data(), 64'h00000000000fffff, 1'b1);
    wait_drain();
    chk("t1_nbeats", obs_q.size(), 2);
    o = obs_q[$];
    chk("t1_mty", o.mty, 44);
    chk("t1_err", o.err, 0);
    chk("t1_meta", {o.mdata, o.qid, o.port}, {32'h4A, 11'h12, 3'd5});
    chk("t1_len", last_plen, 84);
    chk("t1_cnt", pkt_cnt, 1);

    // short last beat, then single full beat
    obs_q.delete();
    send_pkt(2, '1, 64'h3);
    wait_drain();
    chk("t2_mty", obs_q[$].mty, 62);
    chk("t2_len", last_plen, 66);
    send_pkt(1, '1, '1);
    wait_drain();
    chk("t2s_mty", obs_q[$].mty, 0);
    chk("t2s_len", last_plen, 64);

    // stall: two beats fill out reg + skid, then ready drops
    m_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(rnd_data(), '1, 1'b0);
    send_beat(rnd_data(), '1, 1'b0);
    @(negedge clk);
    chk("stall_sready", s_axis.tready, 0);
    chk("stall_mvalid", m_axis.tvalid, 1);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    m_mode = 1;
    send_beat(rnd_data(), '1, 1'b1);
    wait_drain();
    t0 = $time;
    send_pkt(3, '1, '1);
    send_pkt(3, '1, ones_keep(7));
    chk("thruput", $time - t0, 60);
    wait_drain();

    // keep errors
    obs_q.delete();
    send_pkt(2, '1, 64'h0f0f);
    wait_drain();
    chk("t4_err", obs_q[$].err, 1);
    chk("t4_mty", obs_q[$].mty, 52);
    chk("t4_first_err", obs_q[0].err, 0);
    chk("t4_errcnt", err_cnt, 1);
    obs_q.delete();
    send_pkt(2, 64'h7fffffffffffffff, '1);
    wait_drain();
    chk("t4b_errs", {obs_q[0].err, obs_q[1].err}, 2'b11);

    // zero-byte packets
    obs_q.delete();
    send_pkt(1, '1, '0);
    wait_drain();
    o = obs_q[$];
    chk("t5_zb", {o.zb, o.err}, 2'b10);
    chk("t5_mty", o.mty, 0);
    chk("t5_len", last_plen, 0);
    obs_q.delete();
    send_pkt(2, '1, '0);
    wait_drain();
    chk("t5b_err", obs_q[$].err, 1);
    chk("t5b_counts", {pkt_cnt, err_cnt}, {32'd10, 32'd3});

    // length saturation
    send_pkt(1025, '1, '1);
    wait_drain();
    chk("sat_len", last_plen, 65535);

    // reset mid-packet
    send_beat(rnd_data(), '1, 1'b0);
    aresetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mrst_mvalid", m_axis.tvalid, 0);
    chk("mrst_counts", {pkt_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    obs_q.delete();
    cfg_qid = 11'h3c; cfg_port_id = 3'd6; cfg_mdata = 32'h1234_5678;
    send_beat(rnd_data(), '1, 1'b0);
    cfg_qid = 11'h001;
    send_beat(rnd_data(), ones_keep(10), 1'b1);
    wait_drain();
    o = obs_q[$];
    chk("mrst_meta", {o.mdata, o.qid, o.port, o.err}, {32'h1234_5678, 11'h3c, 3'd6, 1'b0});
    chk("mrst_cnt", pkt_cnt, 1);
    chk("mrst_len", last_plen, 74);

    // randomized traffic
    m_mode = 2; cfg_rand = 1;
    for (int p = 0; p < 150; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        logic [63:0] k;
        if ($urandom_range(9) == 0) k = {$urandom, $urandom};
        else if (i == nb - 1) k = ones_keep($urandom_range(0, 64));
        else k = '1;
        if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
        send_beat(rnd_data(), k, i == nb - 1);
      end
    end
    m_mode = 1;
    wait_drain();
    chk("final_cnt", {pkt_cnt, err_cnt}, {exp_cnt, exp_errc});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/h2c_keep_to_mty_adapter.md
Name: h2c_keep_to_mty_adapter

Overview:
- Sits directly upstream of the open_nic_shell QDMA H2C simulation/ingress port, or of any stage that takes the QDMA H2C tuser format.
- Converts a standard 512-bit AXI4-Stream carrying tkeep into the QDMA H2C format: tuser_mty, tuser_zero_byte, tuser_err, tuser_mdata, tuser_qid, tuser_port_id and tcrc.
- Checks keep legality, measures packet length and keeps packet and error counters.
- Decouples the two sides with a full-throughput skid buffer.

Parameters:
- DATA_W, 512, stream data width in bits.
- KEEP_W, 64, byte lanes (DATA_W/8).
- MTY_W, 6, log2(KEEP_W).
- QID_W, 11, QDMA queue id width.
- PORT_W, 3, port id width.
- MDATA_W, 32, metadata width.
- LEN_W, 16, packet length counter width.

Ports:
- axis_aclk  in  1  single clock.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tkeep  in  KEEP_W  byte enables; bit 0 = byte 0.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- cfg_qid  in  QID_W  queue id, sampled at start of packet (SOP).
- cfg_port_id  in  PORT_W  port id, sampled at SOP.
- cfg_mdata  in  MDATA_W  metadata, sampled at SOP.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of packet.
- m_axis_tuser_mty  out  MTY_W  count of empty bytes on the last beat.
- m_axis_tuser_zero_byte  out  1  zero-length packet.
- m_axis_tuser_err  out  1  malformed keep seen in this packet.
- m_axis_tuser_mdata  out  MDATA_W  cfg_mdata latched at SOP.
- m_axis_tuser_qid  out  QID_W  cfg_qid latched at SOP.
- m_axis_tuser_port_id  out  PORT_W  cfg_port_id latched at SOP.
- m_axis_tcrc  out  32  constant 0.
- pkt_len  out  LEN_W  byte length of the last completed packet.
- pkt_len_valid  out  1  one-cycle pulse when pkt_len updates.
- pkt_cnt  out  32  packets emitted.
- err_cnt  out  32  packets emitted with tuser_err=1.

Behaviour:
- Reset values (aresetn=0 at a clock edge):
  - All outputs 0, including m_axis_tvalid and the counters.
  - s_axis_tready=1 in the cycle after reset is released.
  - Skid and output registers empty; FSM in IDLE.
- Reset mid-packet: the partial packet is discarded. After release, the next accepted beat is treated as SOP.
- Handshake:
  - A beat transfers when valid && ready.
  - Latency from input accept to m_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle.
  - Once asserted, m_axis_tvalid and all m_axis_* fields hold stable until m_axis_tready.
  - s_axis_tready is registered and equals "skid register empty". When the output register is full and m_axis_tready=0, one more beat goes to the skid register and tready drops next cycle.
  - No beat is ever lost or duplicated.
- FSM:
  - IDLE: the accepted beat is SOP. Latch cfg_qid, cfg_port_id and cfg_mdata; clear err_sticky and len_acc. Go to IN_PKT if tlast=0; stay in IDLE if tlast=1.
  - IN_PKT: an accepted beat with tlast=1 returns the FSM to IDLE.
- Keep rules, applied per accepted beat:
  - Non-last beat: keep must be all ones, else err.
  - Last beat: keep must be contiguous from bit 0 (of the form 2^n-1), else err.
  - mty = KEEP_W-1-msb_index(keep).
  - Last-beat keep==0: zero_byte=1, mty=0.
  - keep==0 on a non-last beat: err.
  - zero_byte is legal only on a single-beat packet. On a multi-beat packet it also sets err.
- Error handling: err_sticky is set on the first bad beat. tuser_err=1 from that beat through tlast inclusive.
- mty and zero_byte are 0 on non-last beats.
- Length accounting:
  - len_acc += KEEP_W on non-last beats.
  - len_acc += KEEP_W-mty on the last beat, or +0 if zero_byte.
  - Saturates at 2^LEN_W-1.
- Stats update on the output handshake of a tlast beat:
  - pkt_len <= final length, with a pkt_len_valid pulse in the same cycle.
  - pkt_cnt increments.
  - err_cnt increments if tuser_err=1.
  - Both counters wrap modulo 2^32.
- Simultaneous input accept and output drain in one cycle is supported; skid occupancy stays unchanged.

Decomposition:
- Package h2c_adapter_pkg:
  - Width constants.
  - Typedef h2c_tuser_t, a struct of mty, zero_byte, err, mdata, qid and port_id.
  - Functions keep_msb_idx() and keep_is_contig().
- Sub-module axis_skid_buffer: a 2-entry register slice parameterised on payload width. The payload is {tdata, tlast, h2c_tuser_t}.
- Top level holds the FSM, keep checks, length accumulator and counters.

Test Plan:
- Two-beat packet, keep 0xffffffffffffffff then 0x00000000000fffff, m_tready=1:
  - Beat 2 has tlast=1 and mty=44.
  - pkt_len=84 with a pkt_len_valid pulse; pkt_cnt=1; err=0.
  - qid, port_id and mdata equal the SOP values (e.g. mdata=0x4A) even though cfg changes mid-packet.
- Last-beat keep 0x3 -> mty=62, pkt_len=66. Single-beat full-keep packet -> mty=0, pkt_len=64.
- Back-to-back 3-beat packets while m_tready toggles 0 for 3 cycles:
  - s_tready falls one cycle after the second stalled beat.
  - Output order and data are identical to the input; no gaps when m_tready=1.
- Last-beat keep 0x0f0f -> tuser_err=1, mty=52, err_cnt=1.
  - A non-last beat with keep 0x7fffffffffffffff -> err=1 on that beat and on tlast.
- Single beat with keep=0 and tlast=1 -> zero_byte=1, mty=0, pkt_len=0, err=0.
  - The same keep on the 2nd beat of a 2-beat packet -> err=1.
- Assert aresetn=0 mid-packet after beat 1 -> m_tvalid=0 and counters 0.
  - The next packet is latched as SOP with fresh cfg values and is emitted correctly.
